// File: rtl/fib_seq_gen_if.sv
// ============================================================================
// Module : fib_seq_gen_if
// Brief  : Start/done_tick request bus for the generalised-Fibonacci engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fib_seq_gen_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
);
  logic              start;
  logic [IDX_W-1:0]  i;
  logic [DATA_W-1:0] seed0;
  logic [DATA_W-1:0] seed1;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              done_tick;
  logic [DATA_W-1:0] f;
  logic              ovf;

  modport master (
    output start, i, seed0, seed1, abort,
    input  ready, busy, done_tick, f, ovf
  );

  modport slave (
    input  start, i, seed0, seed1, abort,
    output ready, busy, done_tick, f, ovf
  );
endinterface

`default_nettype wire

// File: rtl/fib_seq_gen.sv
// ============================================================================
// Module : fib_seq_gen
// Brief  : Iterative generalised-Fibonacci term engine, t(n)=t(n-1)+t(n-2)
//          mod 2^DATA_W. Define FIB_SEQ_OVF_EN to add carry-out overflow flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_seq_gen #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  fib_seq_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] t0_q, t0_d;
  logic [DATA_W-1:0] t1_q, t1_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [DATA_W-1:0] f_q, f_d;

`ifdef FIB_SEQ_OVF_EN
  logic              ovf_acc_q, ovf_acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W:0]   sum;
`else
  logic [DATA_W-1:0] sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      t0_q      <= '0;
      t1_q      <= '0;
      n_q       <= '0;
      f_q       <= '0;
`ifdef FIB_SEQ_OVF_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      n_q       <= n_d;
      f_q       <= f_d;
`ifdef FIB_SEQ_OVF_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    n_d       = n_q;
    f_d       = f_q;
`ifdef FIB_SEQ_OVF_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    sum       = {1'b0, t1_q} + {1'b0, t0_q};
`else
    sum       = t1_q + t0_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          t0_d      = bus.seed0;
          t1_d      = bus.seed1;
          n_d       = bus.i;
`ifdef FIB_SEQ_OVF_EN
          ovf_acc_d = 1'b0;
`endif
          state_d   = OP;
        end
      end

      OP: begin
        // Abort wins over completion so a cancelled run never touches f/ovf.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (n_q == '0) begin
          f_d     = t0_q;
`ifdef FIB_SEQ_OVF_EN
          ovf_d   = ovf_acc_q;
`endif
          state_d = DONE;
        end else if (n_q == IDX_W'(1)) begin
          f_d     = t1_q;
`ifdef FIB_SEQ_OVF_EN
          ovf_d   = ovf_acc_q;
`endif
          state_d = DONE;
        end else begin
          t1_d      = sum[DATA_W-1:0];
          t0_d      = t1_q;
          n_d       = n_q - IDX_W'(1);
`ifdef FIB_SEQ_OVF_EN
          ovf_acc_d = ovf_acc_q | sum[DATA_W];
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q == OP) || (state_q == DONE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.f         = f_q;
`ifdef FIB_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
// ============================================================================
// Module : tb_fib_seq_gen
// Brief  : Directed self-checking bench for fib_seq_gen (32-bit and 8-bit
//          instances); honours FIB_SEQ_OVF_EN for the expected ovf values.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_seq_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

`ifdef FIB_SEQ_OVF_EN
  localparam bit EXP_OVF14 = 1'b1;
`else
  localparam bit EXP_OVF14 = 1'b0;
`endif

  fib_seq_gen_if #(.DATA_W(32), .IDX_W(6)) bus32 ();
  fib_seq_gen_if #(.DATA_W(8),  .IDX_W(6)) bus8 ();

  fib_seq_gen #(.DATA_W(32), .IDX_W(6)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  fib_seq_gen #(.DATA_W(8), .IDX_W(6)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input bit st, input int idx, input logic [31:0] s0, input logic [31:0] s1);
    if (w8) begin
      bus8.start = st;
      bus8.i     = idx[5:0];
      bus8.seed0 = s0[7:0];
      bus8.seed1 = s1[7:0];
    end else begin
      bus32.start = st;
      bus32.i     = idx[5:0];
      bus32.seed0 = s0;
      bus32.seed1 = s1;
    end
  endtask

  function automatic logic obs_ready(input bit w8);
    return w8 ? bus8.ready : bus32.ready;
  endfunction

  function automatic logic obs_busy(input bit w8);
    return w8 ? bus8.busy : bus32.busy;
  endfunction

  function automatic logic obs_done(input bit w8);
    return w8 ? bus8.done_tick : bus32.done_tick;
  endfunction

  function automatic logic [31:0] obs_f(input bit w8);
    return w8 ? {24'b0, bus8.f} : bus32.f;
  endfunction

  function automatic logic obs_ovf(input bit w8);
    return w8 ? bus8.ovf : bus32.ovf;
  endfunction

  // One full request: wait for ready, accept, measure edges to done_tick.
  // With hold set, start stays high (and the inputs are scrambled) while busy.
  task automatic run(input string tag, input bit w8, input int idx,
                     input logic [31:0] s0, input logic [31:0] s1, input bit hold,
                     input logic [31:0] exp_f, input bit exp_ovf, input int exp_lat,
                     output int idle);
    int lat;
    idle = 0;
    for (int k = 0; k < 100; k++) begin
      if (!obs_busy(w8)) idle++;
      if (obs_ready(w8)) break;
      tick();
    end
    check({tag, "_ready"}, 64'(obs_ready(w8)), 64'd1);
    drive(w8, 1'b1, idx, s0, s1);
    tick();
    if (hold) drive(w8, 1'b1, 0, 32'd7, 32'd7);
    else      drive(w8, 1'b0, idx, s0, s1);
    lat = 1;
    while (!obs_done(w8) && lat < 200) begin
      tick();
      lat++;
    end
    drive(w8, 1'b0, 0, 32'd0, 32'd0);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_f"},   64'(obs_f(w8)), 64'(exp_f));
    check({tag, "_ovf"}, 64'(obs_ovf(w8)), 64'(exp_ovf));
  endtask

  task automatic count_done(input bit w8, input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (obs_done(w8)) cnt++;
    end
  endtask

  initial begin
    int idle;
    int cnt;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 0, 32'd0, 32'd0);
    bus32.abort = 1'b0;
    bus8.abort  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    check("rst_ready", 64'(bus32.ready), 64'd1);
    check("rst_busy",  64'(bus32.busy), 64'd0);
    check("rst_done",  64'(bus32.done_tick), 64'd0);
    check("rst_f",     64'(bus32.f), 64'd0);
    check("rst_ovf",   64'(bus32.ovf), 64'd0);
    check("rst_f8",    64'(bus8.f), 64'd0);

    run("fib10", 1'b0, 10, 32'd0, 32'd1, 1'b0, 32'd55, 1'b0, 11, idle);

    // Reset in the middle of a long run.
    tick();
    drive(1'b0, 1'b1, 20, 32'd0, 32'd1);
    tick();
    drive(1'b0, 1'b0, 20, 32'd0, 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", 64'(bus32.ready), 64'd1);
    check("midrst_busy",  64'(bus32.busy), 64'd0);
    check("midrst_done",  64'(bus32.done_tick), 64'd0);
    check("midrst_f",     64'(bus32.f), 64'd0);
    rst = 1'b0;
    count_done(1'b0, 25, cnt);
    check("midrst_no_done", 64'(cnt), 64'd0);

    run("fib0", 1'b0, 0, 32'd0, 32'd1, 1'b0, 32'd0, 1'b0, 2, idle);
    run("fib1", 1'b0, 1, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0, 2, idle);

    run("lucas5", 1'b0, 5, 32'd2, 32'd1, 1'b1, 32'd11, 1'b0, 6, idle);
    count_done(1'b0, 10, cnt);
    check("lucas5_single_done", 64'(cnt), 64'd0);
    check("lucas5_f_held",      64'(bus32.f), 64'd11);

    run("w8_fib13", 1'b1, 13, 32'd0, 32'd1, 1'b0, 32'd233, 1'b0, 14, idle);
    run("w8_fib14", 1'b1, 14, 32'd0, 32'd1, 1'b0, 32'd121, EXP_OVF14, 15, idle);
    run("w8_fib3",  1'b1, 3,  32'd0, 32'd1, 1'b0, 32'd2,   1'b0, 4, idle);

    // Abort a run four cycles after its accept edge.
    run("pre_abort", 1'b0, 10, 32'd0, 32'd1, 1'b0, 32'd55, 1'b0, 11, idle);
    tick();
    drive(1'b0, 1'b1, 20, 32'd0, 32'd1);
    tick();
    drive(1'b0, 1'b0, 20, 32'd0, 32'd1);
    repeat (3) tick();
    bus32.abort = 1'b1;
    tick();
    bus32.abort = 1'b0;
    check("abort_ready", 64'(bus32.ready), 64'd1);
    check("abort_busy",  64'(bus32.busy), 64'd0);
    check("abort_done",  64'(bus32.done_tick), 64'd0);
    check("abort_f",     64'(bus32.f), 64'd55);
    count_done(1'b0, 25, cnt);
    check("abort_no_done", 64'(cnt), 64'd0);
    run("fib20", 1'b0, 20, 32'd0, 32'd1, 1'b0, 32'd6765, 1'b0, 21, idle);

    run("b2b_fib2", 1'b0, 2, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0, 3, idle);
    run("b2b_fib3", 1'b0, 3, 32'd0, 32'd1, 1'b0, 32'd2, 1'b0, 4, idle);
    check("b2b_idle_gap", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
